rob_commit_unit: RTL and testbench

Parametrised reorder buffer with in-order retire. It sits between rename/dispatch and the free list / architectural RAT. It allocates up to DISPATCH_W entries per cycle with full back-pressure, and marks entries complete from WB_W writeback ports. It retires up to RETIRE_W oldest completed entries per cycle, with WAW-filtered architectural-RAT writes and old-preg release. A precise exception at the head raises a one-cycle flush carrying the faulting PC.

---
 rtl/rob_pkg.sv | 34 +++
 rtl/rob_retire_sel.sv | 96 +++++++++
 rtl/rob_commit_unit.sv | 178 +++++++++++++++++
 tb/tb_rob_commit_unit.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types, default widths and helpers for the reorder buffer.
package rob_pkg;

    localparam int unsigned ROB_DEPTH      = 32;
    localparam int unsigned ROB_DISPATCH_W = 4;
    localparam int unsigned ROB_WB_W       = 4;
    localparam int unsigned ROB_RETIRE_W   = 4;
    localparam int unsigned ROB_AREG_W     = 5;
    localparam int unsigned ROB_PREG_W     = 6;
    localparam int unsigned ROB_PC_W       = 64;
    localparam int unsigned ROB_TYPE_W     = 7;

    typedef struct packed {
        logic                  valid;
        logic                  complete;
        logic                  exc;
        logic                  areg_v;
        logic [ROB_AREG_W-1:0] areg;
        logic [ROB_PREG_W-1:0] preg;
        logic [ROB_PREG_W-1:0] opreg;
        logic [ROB_PC_W-1:0]   pc;
        logic [ROB_TYPE_W-1:0] itype;
    } rob_entry_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Retire selection over the oldest RETIRE_W entries: in-order prefix,
// WAW-filtered RAT writes and head exception detection.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int unsigned RETIRE_W = ROB_RETIRE_W,
    parameter int unsigned IDX_W    = $clog2(ROB_DEPTH)
) (
    input  rob_entry_t [RETIRE_W-1:0]           head_ent,
    input  logic [IDX_W:0]                      count,
    output logic [RETIRE_W-1:0]                 retire_valid_c,
    output logic [$clog2(RETIRE_W+1)-1:0]       retire_cnt_c,
    output logic [RETIRE_W-1:0]                 rat_we_c,
    output logic                                flush_req_c,
    output logic [ROB_PC_W-1:0]                 flush_pc_c,
    output logic [RETIRE_W-1:0]                 retire_areg_v_c,
    output logic [RETIRE_W-1:0][ROB_PREG_W-1:0] retire_opreg_c,
    output logic [RETIRE_W-1:0][ROB_AREG_W-1:0] rat_areg_c,
    output logic [RETIRE_W-1:0][ROB_PREG_W-1:0] rat_preg_c,
    output logic [RETIRE_W-1:0][ROB_TYPE_W-1:0] retire_type_c
);

    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(RETIRE_W + 1);

    logic [RETIRE_W-1:0] done;
    logic [RETIRE_W-1:0] faulting;
    logic [ROB_PC_W-1:0] exc_pc;
    logic                go;

    // Per-lane status: occupied and completed, split by exception flag.
    always_comb begin
        done     = '0;
        faulting = '0;
        for (int k = 0; k < int'(RETIRE_W); k++) begin
            done[k]     = (PTR_W'(k) < count) && head_ent[k].valid && head_ent[k].complete
                          && !head_ent[k].exc;
            faulting[k] = (PTR_W'(k) < count) && head_ent[k].valid && head_ent[k].complete
                          && head_ent[k].exc;
        end
    end

    assign flush_req_c = faulting[0];

    always_comb begin
        retire_valid_c = '0;
        go             = !flush_req_c;
        for (int k = 0; k < int'(RETIRE_W); k++) begin
            go                = go && done[k];
            retire_valid_c[k] = go;
        end
    end

    assign retire_cnt_c = CNT_W'(popcount(32'(retire_valid_c)));

    // A younger retiring write to the same areg supersedes older ones.
    always_comb begin
        rat_we_c = '0;
        for (int k = 0; k < int'(RETIRE_W); k++) begin
            rat_we_c[k] = retire_valid_c[k] && head_ent[k].areg_v;
            for (int j = k + 1; j < int'(RETIRE_W); j++) begin
                if (retire_valid_c[j] && head_ent[j].areg_v
                    && (head_ent[j].areg == head_ent[k].areg)) begin
                    rat_we_c[k] = 1'b0;
                end
            end
        end
    end

    // Oldest faulting lane's PC; only exported when that lane is the head.
    always_comb begin
        exc_pc = '0;
        for (int k = int'(RETIRE_W) - 1; k >= 0; k--) begin
            if (faulting[k]) begin
                exc_pc = head_ent[k].pc;
            end
        end
        flush_pc_c = flush_req_c ? exc_pc : '0;
    end

    always_comb begin
        retire_areg_v_c = '0;
        retire_opreg_c  = '0;
        rat_areg_c      = '0;
        rat_preg_c      = '0;
        retire_type_c   = '0;
        for (int k = 0; k < int'(RETIRE_W); k++) begin
            retire_areg_v_c[k] = head_ent[k].areg_v;
            retire_opreg_c[k]  = head_ent[k].opreg;
            rat_areg_c[k]      = head_ent[k].areg;
            rat_preg_c[k]      = head_ent[k].preg;
            retire_type_c[k]   = head_ent[k].itype;
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: multi-lane allocate, writeback completion, in-order
// retire with RAT/free-list outputs, and precise-exception flush.
module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH      = ROB_DEPTH,
    parameter int unsigned DISPATCH_W = ROB_DISPATCH_W,
    parameter int unsigned WB_W       = ROB_WB_W,
    parameter int unsigned RETIRE_W   = ROB_RETIRE_W,
    parameter int unsigned AREG_W     = ROB_AREG_W,
    parameter int unsigned PREG_W     = ROB_PREG_W,
    parameter int unsigned PC_W       = ROB_PC_W,
    parameter int unsigned TYPE_W     = ROB_TYPE_W,
    parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DISPATCH_W-1:0]               disp_valid,
    output logic                                disp_ready,
    input  logic [DISPATCH_W-1:0]               disp_areg_v,
    input  logic [DISPATCH_W-1:0][AREG_W-1:0]   disp_areg,
    input  logic [DISPATCH_W-1:0][PREG_W-1:0]   disp_preg,
    input  logic [DISPATCH_W-1:0][PREG_W-1:0]   disp_opreg,
    input  logic [DISPATCH_W-1:0][PC_W-1:0]     disp_pc,
    input  logic [DISPATCH_W-1:0]               disp_exc,
    input  logic [DISPATCH_W-1:0][TYPE_W-1:0]   disp_type,
    output logic [DISPATCH_W-1:0][IDX_W-1:0]    disp_idx,
    input  logic [WB_W-1:0]                     wb_valid,
    input  logic [WB_W-1:0][IDX_W-1:0]          wb_idx,
    output logic [RETIRE_W-1:0]                 retire_valid,
    output logic [$clog2(RETIRE_W+1)-1:0]       retire_cnt,
    output logic [RETIRE_W-1:0]                 retire_areg_v,
    output logic [RETIRE_W-1:0][PREG_W-1:0]     retire_opreg,
    output logic [RETIRE_W-1:0]                 rat_we,
    output logic [RETIRE_W-1:0][AREG_W-1:0]     rat_areg,
    output logic [RETIRE_W-1:0][PREG_W-1:0]     rat_preg,
    output logic [RETIRE_W-1:0][TYPE_W-1:0]     retire_type,
    output logic                                flush,
    output logic [PC_W-1:0]                     flush_pc,
    output logic [IDX_W:0]                      rob_count,
    output logic                                rob_empty
);

    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(RETIRE_W + 1);

    rob_entry_t rob_q [DEPTH];
    rob_entry_t rob_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] slot;
    logic             alloc_c;

    rob_entry_t [RETIRE_W-1:0]           head_ent;
    logic                                flush_req;
    logic [CNT_W-1:0]                    ret_cnt;
    logic [ROB_PC_W-1:0]                 sel_pc;
    logic [RETIRE_W-1:0][ROB_PREG_W-1:0] sel_opreg;
    logic [RETIRE_W-1:0][ROB_AREG_W-1:0] sel_areg;
    logic [RETIRE_W-1:0][ROB_PREG_W-1:0] sel_preg;
    logic [RETIRE_W-1:0][ROB_TYPE_W-1:0] sel_type;

    // Wrap bit makes full (count == DEPTH) distinguishable from empty.
    assign count      = tail_q - head_q;
    assign rob_count  = count;
    assign rob_empty  = (count == '0);
    assign disp_ready = !flush_req && ((PTR_W'(DEPTH) - count) >= PTR_W'(DISPATCH_W));
    assign alloc_c    = disp_ready && (|disp_valid);

    always_comb begin
        head_ent = '0;
        disp_idx = '0;
        for (int k = 0; k < int'(RETIRE_W); k++) begin
            head_ent[k] = rob_q[head_q[IDX_W-1:0] + IDX_W'(k)];
        end
        for (int i = 0; i < int'(DISPATCH_W); i++) begin
            disp_idx[i] = tail_q[IDX_W-1:0] + IDX_W'(i);
        end
    end

    rob_retire_sel #(
        .RETIRE_W (RETIRE_W),
        .IDX_W    (IDX_W)
    ) u_retire_sel (
        .head_ent        (head_ent),
        .count           (count),
        .retire_valid_c  (retire_valid),
        .retire_cnt_c    (ret_cnt),
        .rat_we_c        (rat_we),
        .flush_req_c     (flush_req),
        .flush_pc_c      (sel_pc),
        .retire_areg_v_c (retire_areg_v),
        .retire_opreg_c  (sel_opreg),
        .rat_areg_c      (sel_areg),
        .rat_preg_c      (sel_preg),
        .retire_type_c   (sel_type)
    );

    assign retire_cnt = ret_cnt;
    assign flush      = flush_req;
    assign flush_pc   = PC_W'(sel_pc);

    always_comb begin
        retire_opreg = '0;
        rat_areg     = '0;
        rat_preg     = '0;
        retire_type  = '0;
        for (int k = 0; k < int'(RETIRE_W); k++) begin
            retire_opreg[k] = PREG_W'(sel_opreg[k]);
            rat_areg[k]     = AREG_W'(sel_areg[k]);
            rat_preg[k]     = PREG_W'(sel_preg[k]);
            retire_type[k]  = TYPE_W'(sel_type[k]);
        end
    end

    // Order matters: writeback, then retire clear, then allocate overwrite.
    always_comb begin
        rob_d  = rob_q;
        head_d = head_q;
        tail_d = tail_q;
        slot   = '0;
        if (flush_req) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                rob_d[e].valid    = 1'b0;
                rob_d[e].complete = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            for (int p = 0; p < int'(WB_W); p++) begin
                if (wb_valid[p] && rob_q[wb_idx[p]].valid) begin
                    rob_d[wb_idx[p]].complete = 1'b1;
                end
            end
            for (int k = 0; k < int'(RETIRE_W); k++) begin
                if (retire_valid[k]) begin
                    slot                 = head_q[IDX_W-1:0] + IDX_W'(k);
                    rob_d[slot].valid    = 1'b0;
                    rob_d[slot].complete = 1'b0;
                end
            end
            head_d = head_q + PTR_W'(ret_cnt);
            if (alloc_c) begin
                for (int i = 0; i < int'(DISPATCH_W); i++) begin
                    if (disp_valid[i]) begin
                        slot        = tail_q[IDX_W-1:0] + IDX_W'(i);
                        rob_d[slot] = '{valid:    1'b1,
                                        complete: 1'b0,
                                        exc:      disp_exc[i],
                                        areg_v:   disp_areg_v[i],
                                        areg:     ROB_AREG_W'(disp_areg[i]),
                                        preg:     ROB_PREG_W'(disp_preg[i]),
                                        opreg:    ROB_PREG_W'(disp_opreg[i]),
                                        pc:       ROB_PC_W'(disp_pc[i]),
                                        itype:    ROB_TYPE_W'(disp_type[i])};
                    end
                end
                tail_d = tail_q + PTR_W'(popcount(32'(disp_valid)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < int'(DEPTH); e++) begin
                rob_q[e] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            rob_q  <= rob_d;
        end
    end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios plus random traffic checked
// against an in-order queue model of the ROB.
module tb_rob_commit_unit;

    localparam int DEPTH = 32;
    localparam int DW    = 4;
    localparam int WW    = 4;
    localparam int RW    = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       disp_valid;
    logic             disp_ready;
    logic [3:0]       disp_areg_v;
    logic [3:0][4:0]  disp_areg;
    logic [3:0][5:0]  disp_preg;
    logic [3:0][5:0]  disp_opreg;
    logic [3:0][63:0] disp_pc;
    logic [3:0]       disp_exc;
    logic [3:0][6:0]  disp_type;
    logic [3:0][4:0]  disp_idx;
    logic [3:0]       wb_valid;
    logic [3:0][4:0]  wb_idx;
    logic [3:0]       retire_valid;
    logic [2:0]       retire_cnt;
    logic [3:0]       retire_areg_v;
    logic [3:0][5:0]  retire_opreg;
    logic [3:0]       rat_we;
    logic [3:0][4:0]  rat_areg;
    logic [3:0][5:0]  rat_preg;
    logic [3:0][6:0]  retire_type;
    logic             flush;
    logic [63:0]      flush_pc;
    logic [5:0]       rob_count;
    logic             rob_empty;

    rob_commit_unit dut (
        .clk           (clk),
        .rst           (rst),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_areg_v   (disp_areg_v),
        .disp_areg     (disp_areg),
        .disp_preg     (disp_preg),
        .disp_opreg    (disp_opreg),
        .disp_pc       (disp_pc),
        .disp_exc      (disp_exc),
        .disp_type     (disp_type),
        .disp_idx      (disp_idx),
        .wb_valid      (wb_valid),
        .wb_idx        (wb_idx),
        .retire_valid  (retire_valid),
        .retire_cnt    (retire_cnt),
        .retire_areg_v (retire_areg_v),
        .retire_opreg  (retire_opreg),
        .rat_we        (rat_we),
        .rat_areg      (rat_areg),
        .rat_preg      (rat_preg),
        .retire_type   (retire_type),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .rob_count     (rob_count),
        .rob_empty     (rob_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        exc;
        bit        areg_v;
        bit        complete;
        bit [4:0]  areg;
        bit [5:0]  preg;
        bit [5:0]  opreg;
        bit [6:0]  itype;
        bit [63:0] pc;
        int        idx;
    } ment_t;

    typedef struct {
        logic [3:0] dv;
        logic       exp_ready;
        logic [4:0] exp_idx0;
        logic [5:0] exp_count;
    } vec_t;

    ment_t q[$];      // in-flight instructions, oldest first
    int    m_head;
    int    checks;
    int    errors;
    int    uid;
    vec_t  tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        disp_valid  = '0;
        disp_areg_v = '0;
        disp_areg   = '0;
        disp_preg   = '0;
        disp_opreg  = '0;
        disp_pc     = '0;
        disp_exc    = '0;
        disp_type   = '0;
        wb_valid    = '0;
        wb_idx      = '0;
    endtask

    task automatic set_lane(input int i, input bit av, input int ar, input int pr, input int opr,
                            input logic [63:0] pc, input bit ex, input int ty);
        disp_valid[i]  = 1'b1;
        disp_areg_v[i] = av;
        disp_areg[i]   = 5'(ar);
        disp_preg[i]   = 6'(pr);
        disp_opreg[i]  = 6'(opr);
        disp_pc[i]     = pc;
        disp_exc[i]    = ex;
        disp_type[i]   = 7'(ty);
    endtask

    task automatic fill_lanes(input logic [3:0] dv);
        for (int i = 0; i < DW; i++) begin
            if (dv[i]) begin
                set_lane(i, 1'b1, uid % 32, uid % 64, (uid + 7) % 64, 64'h4000 + 64'(uid * 4), 1'b0, uid % 128);
                uid++;
            end
        end
    endtask

    task automatic set_wb(input int p, input int idx);
        wb_valid[p] = 1'b1;
        wb_idx[p]   = 5'(idx);
    endtask

    // Expected outputs from the model: retire the oldest completed, non-faulting
    // run of up to RW entries; a completed faulting head flushes instead.
    task automatic predict_check(output int nret, output bit fl, output bit rdy);
        int         n;
        logic [3:0] rv_e;
        logic [3:0] we_e;
        n    = q.size();
        fl   = (n > 0) && q[0].complete && q[0].exc;
        nret = 0;
        if (!fl) begin
            while (nret < RW && nret < n && q[nret].complete && !q[nret].exc) nret++;
        end
        rv_e = '0;
        we_e = '0;
        for (int k = 0; k < nret; k++) begin
            rv_e[k] = 1'b1;
            we_e[k] = q[k].areg_v;
            for (int j = k + 1; j < nret; j++) begin
                if (q[j].areg_v && q[j].areg == q[k].areg) we_e[k] = 1'b0;
            end
        end
        rdy = !fl && ((DEPTH - n) >= DW);
        chk("rob_count", 64'(rob_count), 64'(n));
        chk("rob_empty", 64'(rob_empty), 64'(n == 0));
        chk("disp_ready", 64'(disp_ready), 64'(rdy));
        chk("disp_idx0", 64'(disp_idx[0]), 64'((m_head + n) % DEPTH));
        chk("flush", 64'(flush), 64'(fl));
        if (fl) chk("flush_pc", flush_pc, q[0].pc);
        chk("retire_valid", 64'(retire_valid), 64'(rv_e));
        chk("retire_cnt", 64'(retire_cnt), 64'(nret));
        chk("rat_we", 64'(rat_we), 64'(we_e));
        for (int k = 0; k < nret; k++) begin
            chk("retire_areg_v", 64'(retire_areg_v[k]), 64'(q[k].areg_v));
            chk("retire_type", 64'(retire_type[k]), 64'(q[k].itype));
            if (q[k].areg_v) chk("retire_opreg", 64'(retire_opreg[k]), 64'(q[k].opreg));
            if (we_e[k]) begin
                chk("rat_areg", 64'(rat_areg[k]), 64'(q[k].areg));
                chk("rat_preg", 64'(rat_preg[k]), 64'(q[k].preg));
            end
        end
    endtask

    // One clock: check settled outputs, take the edge, advance the model.
    task automatic cycle();
        int    nret;
        int    tail_pre;
        bit    fl;
        bit    rdy;
        ment_t e;
        #1;
        predict_check(nret, fl, rdy);
        tail_pre = (m_head + q.size()) % DEPTH;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            m_head = 0;
        end else begin
            for (int p = 0; p < WW; p++) begin
                if (wb_valid[p]) begin
                    foreach (q[j]) if (q[j].idx == int'(wb_idx[p])) q[j].complete = 1'b1;
                end
            end
            repeat (nret) void'(q.pop_front());
            m_head = (m_head + nret) % DEPTH;
            if (rdy && (|disp_valid)) begin
                for (int i = 0; i < DW; i++) begin
                    if (disp_valid[i]) begin
                        e.exc      = disp_exc[i];
                        e.areg_v   = disp_areg_v[i];
                        e.complete = 1'b0;
                        e.areg     = disp_areg[i];
                        e.preg     = disp_preg[i];
                        e.opreg    = disp_opreg[i];
                        e.itype    = disp_type[i];
                        e.pc       = disp_pc[i];
                        e.idx      = (tail_pre + i) % DEPTH;
                        q.push_back(e);
                    end
                end
            end
        end
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_head = 0;
    endtask

    task automatic drain();
        int budget;
        int np;
        budget = 200;
        while (q.size() > 0 && budget > 0) begin
            np = 0;
            foreach (q[j]) begin
                if (!q[j].complete && np < WW) begin
                    set_wb(np, q[j].idx);
                    np++;
                end
            end
            cycle();
            budget--;
        end
        #1;
        chk("drain_empty", 64'(rob_empty), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        uid    = 0;
        m_head = 0;
        clear_inputs();
        rst = 1'b1;

        // Reset state
        do_reset();
        #1;
        chk("rst_count", 64'(rob_count), 64'(0));
        chk("rst_ready", 64'(disp_ready), 64'(1));
        chk("rst_empty", 64'(rob_empty), 64'(1));
        chk("rst_flush", 64'(flush), 64'(0));
        chk("rst_flush_pc", flush_pc, 64'(0));
        chk("rst_retire_valid", 64'(retire_valid), 64'(0));
        chk("rst_rat_we", 64'(rat_we), 64'(0));
        chk("rst_retire_cnt", 64'(retire_cnt), 64'(0));

        // Fill to capacity; the ninth group must be refused
        for (int r = 0; r < 9; r++) begin
            tbl[r].dv        = 4'hF;
            tbl[r].exp_ready = (r < 8);
            tbl[r].exp_idx0  = 5'((4 * r) % DEPTH);
            tbl[r].exp_count = (r < 8) ? 6'(4 * r) : 6'd32;
        end
        for (int r = 0; r < 9; r++) begin
            fill_lanes(tbl[r].dv);
            #1;
            chk("tbl_ready", 64'(disp_ready), 64'(tbl[r].exp_ready));
            chk("tbl_idx0", 64'(disp_idx[0]), 64'(tbl[r].exp_idx0));
            chk("tbl_count", 64'(rob_count), 64'(tbl[r].exp_count));
            cycle();
        end
        #1;
        chk("full_count", 64'(rob_count), 64'(32));
        chk("full_ready", 64'(disp_ready), 64'(0));
        chk("full_tail", 64'(disp_idx[1]), 64'(1));

        // Out-of-order completion: entry 2 blocks retire
        do_reset();
        fill_lanes(4'hF); cycle();
        fill_lanes(4'hF); cycle();
        set_wb(0, 3); set_wb(1, 1); set_wb(2, 0);
        cycle();
        #1;
        chk("ooo_retire_valid", 64'(retire_valid), 64'(4'b0011));
        chk("ooo_retire_cnt", 64'(retire_cnt), 64'(2));
        cycle();

        // WAW: four writes to areg 5, youngest wins
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 5, 10 + i, 20 + i, 64'h100 + 64'(i * 4), 1'b0, i);
        cycle();
        for (int p = 0; p < 4; p++) set_wb(p, p);
        cycle();
        #1;
        chk("waw_rat_we", 64'(rat_we), 64'(4'b1000));
        chk("waw_rat_preg3", 64'(rat_preg[3]), 64'(13));
        for (int k = 0; k < 4; k++) chk("waw_opreg", 64'(retire_opreg[k]), 64'(20 + k));
        cycle();

        // Head wrap: move head to 30, then retire 30,31,0,1
        do_reset();
        for (int g = 0; g < 7; g++) begin
            fill_lanes(4'hF);
            cycle();
        end
        fill_lanes(4'h3);
        cycle();
        drain();
        chk("wrap_start_idx", 64'(disp_idx[0]), 64'(30));
        fill_lanes(4'hF);
        cycle();
        set_wb(0, 30); set_wb(1, 31); set_wb(2, 0); set_wb(3, 1);
        cycle();
        #1;
        chk("wrap_retire_cnt", 64'(retire_cnt), 64'(4));
        chk("wrap_retire_valid", 64'(retire_valid), 64'(4'hF));
        cycle();
        #1;
        chk("wrap_count", 64'(rob_count), 64'(0));
        chk("wrap_tail", 64'(disp_idx[0]), 64'(2));

        // Exception in lane 2: truncate, then flush from the head
        do_reset();
        for (int i = 0; i < 4; i++)
            set_lane(i, 1'b1, i, 30 + i, 40 + i, (i == 2) ? 64'h1000 : 64'h800 + 64'(i * 4), i == 2, i);
        cycle();
        for (int p = 0; p < 4; p++) set_wb(p, p);
        cycle();
        #1;
        chk("exc_a_retire_valid", 64'(retire_valid), 64'(4'b0011));
        chk("exc_a_flush", 64'(flush), 64'(0));
        cycle();
        fill_lanes(4'hF);
        #1;
        chk("exc_b_flush", 64'(flush), 64'(1));
        chk("exc_b_flush_pc", flush_pc, 64'h1000);
        chk("exc_b_retire_valid", 64'(retire_valid), 64'(0));
        chk("exc_b_ready", 64'(disp_ready), 64'(0));
        cycle();
        #1;
        chk("exc_after_empty", 64'(rob_empty), 64'(1));
        chk("exc_after_tail", 64'(disp_idx[0]), 64'(0));
        chk("exc_after_flush", 64'(flush), 64'(0));

        // Reset mid-operation with writebacks pending
        do_reset();
        for (int g = 0; g < 3; g++) begin
            fill_lanes(4'hF);
            cycle();
        end
        for (int p = 0; p < 4; p++) set_wb(p, p);
        fill_lanes(4'hF);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        q.delete();
        m_head = 0;
        #1;
        chk("mid_rst_count", 64'(rob_count), 64'(0));
        chk("mid_rst_retire_valid", 64'(retire_valid), 64'(0));
        chk("mid_rst_ready", 64'(disp_ready), 64'(1));
        chk("mid_rst_flush", 64'(flush), 64'(0));
        cycle();
        #1;
        chk("mid_rst_still_empty", 64'(rob_empty), 64'(1));

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            n = int'($urandom_range(0, 4));
            for (int i = 0; i < n; i++)
                set_lane(i, ($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 64),
                         int'($urandom % 64), {$urandom, $urandom}, ($urandom % 24) == 0,
                         int'($urandom % 128));
            for (int p = 0; p < WW; p++) begin
                if ($urandom % 2 == 1) begin
                    if (q.size() > 0 && ($urandom % 4) != 0)
                        set_wb(p, q[$urandom_range(0, q.size() - 1)].idx);
                    else
                        set_wb(p, int'($urandom % 32));
                end
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
